alarm_tone_gen: RTL

Parametrised audible-alarm generator driving the PmodAMP2 on JA. It produces a square-wave tone at one of two configurable pitches and sequences it into continuous, beep, siren or chirp patterns with an optional finite burst count. It is the next generation of the single-pitch 440 Hz buzzer: it adds start/stop control, a busy/done status and a mute override. It sits between the game/timer control logic and the amplifier pins.

---
 rtl/alarm_tone_gen_if.sv | 25 ++
 rtl/alarm_tone_gen.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alarm_tone_gen_if.sv
// Control/status bundle between the game/timer logic (master) and the alarm tone generator (slave).
interface alarm_tone_gen_if #(
  parameter int BURST_W = 4
) ();
  logic               start;
  logic               stop;
  logic               mute;
  logic [1:0]         mode;
  logic [BURST_W-1:0] burst_len;
  logic               audio_out;
  logic               amp_gain;
  logic               amp_shdn;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, mute, mode, burst_len,
    input  audio_out, amp_gain, amp_shdn, busy, done
  );

  modport slave (
    input  start, stop, mute, mode, burst_len,
    output audio_out, amp_gain, amp_shdn, busy, done
  );
endinterface

// File: rtl/alarm_tone_gen.sv
// Two-pitch square-wave alarm for the PmodAMP2: sequences continuous, beep, siren and chirp
// patterns slot by slot, with optional burst count, stop, mute and busy/done status.
module alarm_tone_gen #(
  parameter int CLK_HZ    = 100000000,
  parameter int TONE_A_HZ = 440,
  parameter int TONE_B_HZ = 880,
  parameter int SLOT_MS   = 250,
  parameter int BURST_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  alarm_tone_gen_if.slave   bus
);
  localparam int HALF_A   = CLK_HZ / (2 * TONE_A_HZ);
  localparam int HALF_B   = CLK_HZ / (2 * TONE_B_HZ);
  localparam int SLOT_CYC = (CLK_HZ / 1000) * SLOT_MS;
  localparam int HALF_MAX = (HALF_A > HALF_B) ? HALF_A : HALF_B;
  localparam int TW       = (HALF_MAX > 2) ? $clog2(HALF_MAX) : 1;
  localparam int SW       = (SLOT_CYC > 2) ? $clog2(SLOT_CYC) : 1;

  localparam logic [TW-1:0] HALF_A_M1 = TW'(HALF_A - 1);
  localparam logic [TW-1:0] HALF_B_M1 = TW'(HALF_B - 1);
  localparam logic [SW-1:0] SLOT_M1   = SW'(SLOT_CYC - 1);

  if (HALF_A < 2 || HALF_B < 2 || SLOT_CYC < 2 * HALF_MAX) begin : g_param_check
    $error("alarm_tone_gen: tone half-periods must be >= 2 and a slot must hold a full period");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SND  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic [BURST_W-1:0]   rep_q, rep_d;
  logic [SW-1:0]        slot_cnt_q, slot_cnt_d;
  logic                 phase_q, phase_d;
  logic [TW-1:0]        tone_cnt_q, tone_cnt_d;
  logic                 tone_q, tone_d;
  logic                 audio_q, audio_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 use_b_s;
  logic [TW-1:0]        half_m1_s;
  logic                 slot_end_s;
  logic                 unit_end_s;
  logic [BURST_W-1:0]   rep_inc_s;
  logic                 phase_next_s;

  // Pitch select, slot/unit boundaries and the next-state/counter logic.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    burst_d    = burst_q;
    rep_d      = rep_q;
    slot_cnt_d = slot_cnt_q;
    phase_d    = phase_q;
    tone_cnt_d = tone_cnt_q;
    tone_d     = tone_q;
    done_d     = 1'b0;

    use_b_s      = (mode_q == 2'b11) || ((mode_q == 2'b10) && phase_q);
    half_m1_s    = use_b_s ? HALF_B_M1 : HALF_A_M1;
    slot_end_s   = (slot_cnt_q == SLOT_M1);
    unit_end_s   = slot_end_s && ((mode_q == 2'b00) || phase_q);
    rep_inc_s    = rep_q + BURST_W'(1);
    phase_next_s = (mode_q == 2'b00) ? 1'b0 : ~phase_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d    = ST_SND;
          mode_d     = bus.mode;
          burst_d    = bus.burst_len;
          rep_d      = '0;
          slot_cnt_d = '0;
          phase_d    = 1'b0;
          tone_cnt_d = '0;
          tone_d     = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SND, ST_GAP: begin
        if (bus.stop) begin
          state_d    = ST_IDLE;
          rep_d      = '0;
          slot_cnt_d = '0;
          phase_d    = 1'b0;
          tone_cnt_d = '0;
          tone_d     = 1'b0;
        end else if (slot_end_s) begin
          // Every new slot restarts the tone low with a full half-period.
          slot_cnt_d = '0;
          tone_cnt_d = '0;
          tone_d     = 1'b0;
          if (unit_end_s && (burst_q != '0) && (rep_inc_s == burst_q)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            rep_d   = '0;
            phase_d = 1'b0;
          end else begin
            rep_d   = unit_end_s ? rep_inc_s : rep_q;
            phase_d = phase_next_s;
            state_d = (mode_q[0] && phase_next_s) ? ST_GAP : ST_SND;
          end
        end else begin
          slot_cnt_d = slot_cnt_q + SW'(1);
          if (state_q == ST_GAP) begin
            tone_cnt_d = '0;
            tone_d     = 1'b0;
          end else if (tone_cnt_q == half_m1_s) begin
            tone_cnt_d = '0;
            tone_d     = ~tone_q;
          end else begin
            tone_cnt_d = tone_cnt_q + TW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d  = (state_d != ST_IDLE);
    audio_d = (state_d == ST_SND) && tone_d && !bus.mute;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= 2'b00;
      burst_q    <= '0;
      rep_q      <= '0;
      slot_cnt_q <= '0;
      phase_q    <= 1'b0;
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
      audio_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      burst_q    <= burst_d;
      rep_q      <= rep_d;
      slot_cnt_q <= slot_cnt_d;
      phase_q    <= phase_d;
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
      audio_q    <= audio_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.audio_out = audio_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.amp_gain  = 1'b1;
  assign bus.amp_shdn  = busy_q & ~bus.mute;
endmodule
